// File: rtl/game_input_ctrl_pkg.sv
// Shared definitions for the game input front end: state codes and switch encode tables.
package game_pkg;

  localparam int unsigned SW_W    = 4;
  localparam int unsigned SPEED_W = 3;
  localparam int unsigned DIFF_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } game_state_e;

  localparam logic [SPEED_W-1:0] SPEED_MIN = 3'd2;
  localparam logic [DIFF_W-1:0]  DIFF_MIN  = 2'd0;

  // Per-run configuration captured on entry to RUN.
  typedef struct packed {
    logic [SPEED_W-1:0] speed;
    logic [DIFF_W-1:0]  difficulty;
  } game_cfg_t;

  // Highest set switch wins; no switch gives the slowest speed.
  function automatic logic [SPEED_W-1:0] encode_speed(input logic [SW_W-1:0] sw);
    if (sw[3])      return 3'd6;
    else if (sw[2]) return 3'd5;
    else if (sw[1]) return 3'd4;
    else if (sw[0]) return 3'd3;
    else            return SPEED_MIN;
  endfunction

  // Only the upper three difficulty switches carry meaning.
  function automatic logic [DIFF_W-1:0] encode_difficulty(input logic [SW_W-1:1] sw);
    if (sw[3])      return 2'd3;
    else if (sw[2]) return 2'd2;
    else if (sw[1]) return 2'd1;
    else            return DIFF_MIN;
  endfunction

endpackage

// File: rtl/game_input_ctrl_if.sv
// Raw-input / game-control bundle between the board pins and the game core.
interface game_input_ctrl_if;
  import game_pkg::*;

  logic                jump_btn;
  logic                restart_btn;
  logic [SW_W-1:0]     speed_in;
  logic [SW_W-1:0]     difficulty_in;
  logic                isdead;
  logic                jump;
  logic                jump_pulse;
  logic                start;
  logic                game_over;
  logic [SPEED_W-1:0]  speed;
  logic [DIFF_W-1:0]   difficulty;
  logic                game_tick;

  modport master (
    output jump_btn, restart_btn, speed_in, difficulty_in, isdead,
    input  jump, jump_pulse, start, game_over, speed, difficulty, game_tick
  );

  modport slave (
    input  jump_btn, restart_btn, speed_in, difficulty_in, isdead,
    output jump, jump_pulse, start, game_over, speed, difficulty, game_tick
  );
endinterface

// File: rtl/game_input_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and registered rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DB_W            = 20
) (
  input  logic CLK100MHZ,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            rise_q;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing samples; flip the stable level on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  // Synchroniser, debounce state and edge pulse registers.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= stable_d & ~stable_q;
    end
  end

  assign level = stable_q;
  assign rise  = rise_q;

endmodule

// File: rtl/game_input_ctrl.sv
// Game input front end: debounced buttons, IDLE/RUN/DEAD state, frozen run config, tick enable.
module game_input_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DB_W            = 20,
  parameter int unsigned TICK_BIT        = 21
) (
  input logic              CLK100MHZ,
  input logic              reset_n,
  game_input_ctrl_if.slave bus
);

  localparam int unsigned SUM_W = TICK_BIT + 1;

  logic                jump_level, jump_rise;
  logic                restart_level_unused, rst_pulse;
  logic [SW_W-1:0]     spd_sync1_q, spd_sync2_q;
  logic [SW_W-1:1]     dif_sync1_q, dif_sync2_q;
  game_state_e         state_q, state_d;
  logic                start_q, game_over_q;
  game_cfg_t           cfg_q;
  logic [TICK_BIT-1:0] acc_q;
  logic [SUM_W-1:0]    acc_sum_c;
  logic                tick_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_jump_db (
    .CLK100MHZ (CLK100MHZ),
    .reset_n   (reset_n),
    .raw       (bus.jump_btn),
    .level     (jump_level),
    .rise      (jump_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_restart_db (
    .CLK100MHZ (CLK100MHZ),
    .reset_n   (reset_n),
    .raw       (bus.restart_btn),
    .level     (restart_level_unused),
    .rise      (rst_pulse)
  );

  // Game state transitions; restart outranks a collision while running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (jump_rise) state_d = ST_RUN;
      ST_RUN: begin
        if (rst_pulse)       state_d = ST_IDLE;
        else if (bus.isdead) state_d = ST_DEAD;
      end
      ST_DEAD: if (rst_pulse) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign acc_sum_c = SUM_W'(acc_q) + SUM_W'(cfg_q.speed);

  // State, status flags, switch sync, config capture and tick accumulator.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      start_q          <= 1'b0;
      game_over_q      <= 1'b0;
      spd_sync1_q      <= '0;
      spd_sync2_q      <= '0;
      dif_sync1_q      <= '0;
      dif_sync2_q      <= '0;
      cfg_q.speed      <= SPEED_MIN;
      cfg_q.difficulty <= DIFF_MIN;
      acc_q            <= '0;
      tick_q           <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= (state_d == ST_RUN);
      game_over_q <= (state_d == ST_DEAD);
      spd_sync1_q <= bus.speed_in;
      spd_sync2_q <= spd_sync1_q;
      dif_sync1_q <= bus.difficulty_in[SW_W-1:1];
      dif_sync2_q <= dif_sync1_q;
      if (state_q == ST_IDLE) begin
        cfg_q.speed      <= encode_speed(spd_sync2_q);
        cfg_q.difficulty <= encode_difficulty(dif_sync2_q);
      end
      if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
        acc_q  <= acc_sum_c[TICK_BIT-1:0];
        tick_q <= acc_sum_c[TICK_BIT];
      end else begin
        acc_q  <= '0;
        tick_q <= 1'b0;
      end
    end
  end

  assign bus.jump       = jump_level;
  assign bus.jump_pulse = jump_rise;
  assign bus.start      = start_q;
  assign bus.game_over  = game_over_q;
  assign bus.speed      = cfg_q.speed;
  assign bus.difficulty = cfg_q.difficulty;
  assign bus.game_tick  = tick_q;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Randomised scoreboard bench for game_input_ctrl with a behavioural reference model.
module tb_game_input_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned DBW = 3;
  localparam int unsigned TB  = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DEAD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_input_ctrl_if bus_if ();

  game_input_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .DB_W            (DBW),
    .TICK_BIT        (TB)
  ) dut (
    .CLK100MHZ (clk),
    .reset_n   (rst_n),
    .bus       (bus_if.slave)
  );

  typedef struct {
    int jump;
    int jump_pulse;
    int start;
    int game_over;
    int speed;
    int difficulty;
    int game_tick;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Current stimulus values
  bit       c_jb, c_rb, c_dead, c_rn;
  bit [3:0] c_sp, c_df;

  // Reference model: raw input histories (bit i = value driven i cycles ago)
  bit [7:0] jb_h, rb_h;
  bit [3:0] sp_h [3];
  bit [3:0] df_h [3];
  int m_jump, m_jpulse, m_rlvl, m_rpulse;
  int m_state, m_speed, m_diff, m_k, m_tick;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int spd_code(bit [3:0] s);
    if (s[3]) return 6;
    if (s[2]) return 5;
    if (s[1]) return 4;
    if (s[0]) return 3;
    return 2;
  endfunction

  function automatic int diff_code(bit [3:0] s);
    if (s[3]) return 3;
    if (s[2]) return 2;
    if (s[1]) return 1;
    return 0;
  endfunction

  // A level flips once the last DEB synchronised samples all disagree with it
  function automatic int settled(bit [7:0] h, int lvl);
    for (int i = 2; i < 2 + int'(DEB); i++) begin
      if (int'(h[i]) == lvl) return lvl;
    end
    return 1 - lvl;
  endfunction

  function automatic void model_reset();
    jb_h = '0;
    rb_h = '0;
    for (int i = 0; i < 3; i++) begin
      sp_h[i] = '0;
      df_h[i] = '0;
    end
    m_jump = 0; m_jpulse = 0; m_rlvl = 0; m_rpulse = 0;
    m_state = M_IDLE; m_speed = 2; m_diff = 0; m_k = 0; m_tick = 0;
  endfunction

  // Outputs expected after the next clock edge given the inputs just applied
  function automatic void model_step(bit jb, bit rb, bit [3:0] sp, bit [3:0] df, bit dead);
    int old_state, jp, rp, nj, nr;
    old_state = m_state;
    jp = m_jpulse;
    rp = m_rpulse;
    jb_h = {jb_h[6:0], jb};
    rb_h = {rb_h[6:0], rb};
    sp_h[2] = sp_h[1]; sp_h[1] = sp_h[0]; sp_h[0] = sp;
    df_h[2] = df_h[1]; df_h[1] = df_h[0]; df_h[0] = df;
    nj = settled(jb_h, m_jump);
    m_jpulse = (nj == 1 && m_jump == 0) ? 1 : 0;
    m_jump = nj;
    nr = settled(rb_h, m_rlvl);
    m_rpulse = (nr == 1 && m_rlvl == 0) ? 1 : 0;
    m_rlvl = nr;
    if (old_state == M_IDLE && jp == 1)      m_state = M_RUN;
    else if (old_state == M_RUN && rp == 1)  m_state = M_IDLE;
    else if (old_state == M_RUN && dead)     m_state = M_DEAD;
    else if (old_state == M_DEAD && rp == 1) m_state = M_IDLE;
    if (old_state == M_IDLE) begin
      m_speed = spd_code(sp_h[2]);
      m_diff  = diff_code(df_h[2]);
    end
    // Tick k fires when floor(k*speed / 2^TB) steps up
    if (old_state == M_RUN && m_state == M_RUN) begin
      m_k++;
      m_tick = ((m_k * m_speed) / (1 << TB)) != (((m_k - 1) * m_speed) / (1 << TB)) ? 1 : 0;
    end else begin
      m_k = 0;
      m_tick = 0;
    end
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.jump       = m_jump;
    e.jump_pulse = m_jpulse;
    e.start      = (m_state == M_RUN)  ? 1 : 0;
    e.game_over  = (m_state == M_DEAD) ? 1 : 0;
    e.speed      = m_speed;
    e.difficulty = m_diff;
    e.game_tick  = m_tick;
    return e;
  endfunction

  task automatic drive();
    @(posedge clk);
    #2;
    bus_if.jump_btn      = c_jb;
    bus_if.restart_btn   = c_rb;
    bus_if.speed_in      = c_sp;
    bus_if.difficulty_in = c_df;
    bus_if.isdead        = c_dead;
    if (!c_rn) begin
      if (rst_n) begin
        // Asynchronous reset: the pending expectation is replaced by reset values
        rst_n = 1'b0;
        sb_q.delete();
        model_reset();
        sb_q.push_back(snap());
      end else begin
        model_reset();
      end
    end else begin
      rst_n = 1'b1;
      model_step(c_jb, c_rb, c_sp, c_df, c_dead);
    end
    sb_q.push_back(snap());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive();
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #6;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("jump",       int'(bus_if.jump),       e.jump);
        cmp("jump_pulse", int'(bus_if.jump_pulse), e.jump_pulse);
        cmp("start",      int'(bus_if.start),      e.start);
        cmp("game_over",  int'(bus_if.game_over),  e.game_over);
        cmp("speed",      int'(bus_if.speed),      e.speed);
        cmp("difficulty", int'(bus_if.difficulty), e.difficulty);
        cmp("game_tick",  int'(bus_if.game_tick),  e.game_tick);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus_if.jump_btn      = 1'b0;
    bus_if.restart_btn   = 1'b0;
    bus_if.speed_in      = 4'b0000;
    bus_if.difficulty_in = 4'b0000;
    bus_if.isdead        = 1'b0;
    c_jb = 1'b0; c_rb = 1'b0; c_dead = 1'b0; c_rn = 1'b0;
    c_sp = 4'b0000; c_df = 4'b0000;
    model_reset();
    sb_q.push_back(snap());
    run(3);
    c_rn = 1'b1;

    // Short glitch ignored, then a held press starts a run at speed 5
    c_sp = 4'b0100; c_df = 4'b0010;
    c_jb = 1'b1; run(3); c_jb = 1'b0; run(8);
    c_jb = 1'b1; run(10); c_jb = 1'b0; run(40);

    // Speed switch change during RUN is frozen out until the next IDLE
    c_sp = 4'b1000; run(40);
    c_rb = 1'b1; run(6); c_rb = 1'b0; run(8);

    // Collision, ignored jump in DEAD, restart back to IDLE
    c_jb = 1'b1; run(6); c_jb = 1'b0; run(20);
    c_dead = 1'b1; run(1); c_dead = 1'b0; run(5);
    c_jb = 1'b1; run(6); c_jb = 1'b0; run(10);
    c_rb = 1'b1; run(6); c_rb = 1'b0; run(6);

    // Restart pulse coincident with isdead; difficulty bit 0 ignored
    c_df = 4'b0001;
    c_jb = 1'b1; run(6); c_jb = 1'b0; run(12);
    c_rb = 1'b1; run(6); c_dead = 1'b1; run(1); c_dead = 1'b0; c_rb = 1'b0; run(8);

    // Jump and restart pulse together in IDLE
    c_jb = 1'b1; c_rb = 1'b1; run(6); c_jb = 1'b0; c_rb = 1'b0; run(10);

    // Reset mid-run and mid-debounce
    c_jb = 1'b1; run(2); c_rn = 1'b0; run(2); c_rn = 1'b1; run(6); c_jb = 1'b0; run(10);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)  c_jb = ~c_jb;
      if ($urandom_range(0, 23) == 0) c_rb = ~c_rb;
      if ($urandom_range(0, 29) == 0) c_sp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) c_df = 4'($urandom_range(0, 15));
      c_dead = ($urandom_range(0, 40) == 0);
      c_rn   = ($urandom_range(0, 400) != 0);
      drive();
    end
    c_rn = 1'b1; c_dead = 1'b0;
    run(4);

    @(posedge clk);
    #8;
    cmp("scoreboard_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
